// File: rtl/mem_access_splitter.sv
// Load/store front end for a byte-addressed data memory: aligned accesses go out as
// one transfer, misaligned ones are split into single-byte transfers.
module mem_access_splitter #(
  parameter  int unsigned MEM_SIZE = 128,
  localparam int unsigned AW       = 64,
  localparam int unsigned DW       = 64,
  localparam int unsigned SW       = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [SW-1:0] req_size,
  input  logic [DW-1:0] req_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_address,
  output logic          mem_write_enable,
  output logic          mem_read_enable,
  output logic [DW-1:0] mem_write_data,
  output logic [SW-1:0] mem_xfer_size,
  input  logic [DW-1:0] mem_read_data
);

  localparam int unsigned IW = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALIGNED,
    ST_BYTE,
    ST_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [SW-1:0] size_q, size_d;
  logic          write_q, write_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic          mem_re_q, mem_re_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [SW-1:0] mem_size_q, mem_size_d;

  logic req_size_ok_c;
  logic req_illegal_c;
  logic req_aligned_c;
  logic accept_c;
  logic byte_last_c;

  function automatic logic [DW-1:0] size_mask(input logic [SW-1:0] s);
    case (s)
      4'd1:    size_mask = 64'h0000_0000_0000_00FF;
      4'd2:    size_mask = 64'h0000_0000_0000_FFFF;
      4'd4:    size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = '1;
    endcase
  endfunction

  function automatic logic [DW-1:0] byte_lane(input logic [DW-1:0] d, input logic [IW-1:0] k);
    byte_lane = DW'(d[{k, 3'b000} +: 8]);
  endfunction

  // Next-state, datapath and registered-output computation
  always_comb begin
    req_size_ok_c = (req_size == 4'd1) || (req_size == 4'd2) ||
                    (req_size == 4'd4) || (req_size == 4'd8);
    // MEM_SIZE exceeds every legal size, so the subtraction cannot wrap
    req_illegal_c = !req_size_ok_c || (req_addr > (AW'(MEM_SIZE) - AW'(req_size)));
    req_aligned_c = (req_addr & (AW'(req_size) - AW'(1))) == '0;
    accept_c      = req_valid && !busy_q;
    byte_last_c   = (idx_q == IW'(size_q - SW'(1)));

    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_addr_d  = '0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_wdata_d = '0;
    mem_size_d  = SW'(8);

    case (state_q)
      ST_ALIGNED: begin
        if (!write_q) begin
          rdata_d = mem_read_data & size_mask(size_q);
        end
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      ST_BYTE: begin
        if (!write_q) begin
          rdata_d[{idx_q, 3'b000} +: 8] = mem_read_data[7:0];
        end
        if (byte_last_c) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d       = idx_q + IW'(1);
          busy_d      = 1'b1;
          mem_addr_d  = addr_q + AW'(idx_d);
          mem_we_d    = write_q;
          mem_re_d    = !write_q;
          mem_wdata_d = byte_lane(wdata_q, idx_d);
          mem_size_d  = SW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Acceptance is possible in IDLE and in DONE (back-to-back)
    if (accept_c) begin
      addr_d  = req_addr;
      size_d  = req_size;
      write_d = req_write;
      wdata_d = req_wdata;
      idx_d   = '0;
      rdata_d = '0;
      err_d   = 1'b0;
      if (req_illegal_c) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end else if (req_aligned_c) begin
        state_d     = ST_ALIGNED;
        busy_d      = 1'b1;
        mem_addr_d  = req_addr;
        mem_we_d    = req_write;
        mem_re_d    = !req_write;
        mem_wdata_d = req_wdata;
        mem_size_d  = req_size;
      end else begin
        state_d     = ST_BYTE;
        busy_d      = 1'b1;
        mem_addr_d  = req_addr;
        mem_we_d    = req_write;
        mem_re_d    = !req_write;
        mem_wdata_d = byte_lane(req_wdata, '0);
        mem_size_d  = SW'(1);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_wdata_q <= '0;
      mem_size_q  <= SW'(8);
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign rdata          = rdata_q;
  assign mem_address    = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_xfer_size  = mem_size_q;
  // A reset arriving mid-operation must stop the access of that very cycle
  assign mem_write_enable = mem_we_q && !reset;
  assign mem_read_enable  = mem_re_q && !reset;

endmodule

// File: tb/tb_mem_access_splitter.sv
// Scoreboard bench for mem_access_splitter: byte-array memory, spec-level reference
// model, and a negedge monitor checking every memory access and completion.
module tb_mem_access_splitter;

  localparam int unsigned MEM_SIZE = 128;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [63:0] req_addr;
  logic [3:0]  req_size;
  logic [63:0] req_wdata;
  logic        busy, done, err;
  logic [63:0] rdata;
  logic [63:0] mem_address;
  logic        mem_write_enable, mem_read_enable;
  logic [63:0] mem_write_data;
  logic [3:0]  mem_xfer_size;
  logic [63:0] mem_read_data;

  mem_access_splitter #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable), .mem_write_data(mem_write_data),
    .mem_xfer_size(mem_xfer_size), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          lat;
    int          acc;
  } resp_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [3:0]  size;
    logic [63:0] wdata;
    logic [63:0] wmask;
  } access_t;

  resp_t   resp_q[$];
  access_t acc_q[$];

  int n_total = 0;
  int n_pass  = 0;
  bit mon_en  = 1'b0;
  bit mem_clear;
  int last_acc;

  logic [7:0] mem     [MEM_SIZE];
  logic [7:0] ref_mem [MEM_SIZE];
  logic [3:0] size_tab [16] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8,
                                4'd1, 4'd2, 4'd4, 4'd8, 4'd0, 4'd3, 4'd6, 4'd9};

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 73 + 5) ^ 8'h5A);
  endfunction

  function automatic logic [63:0] mask_of(input int sz);
    return (sz >= 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
  endfunction

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Data memory: synchronous write, combinational read
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < int'(MEM_SIZE); i++) mem[i] <= init_byte(i);
    end else if (mem_write_enable) begin
      for (int b = 0; b < 8; b++)
        if (b < int'(mem_xfer_size))
          mem[int'((mem_address + 64'(b)) % 64'(MEM_SIZE))] <= mem_write_data[8*b +: 8];
    end
  end

  always_comb begin
    mem_read_data = '0;
    if (mem_read_enable)
      for (int b = 0; b < 8; b++)
        if (b < int'(mem_xfer_size))
          mem_read_data[8*b +: 8] = mem[int'((mem_address + 64'(b)) % 64'(MEM_SIZE))];
  end

  // Monitor: protocol, access stream and completions
  always @(negedge clk) begin
    access_t a;
    resp_t   r;
    if (mon_en && !reset) begin
      chk(!(mem_read_enable && mem_write_enable), "one_enable",
          64'({mem_read_enable, mem_write_enable}), 64'd1);
      if (!busy)
        chk(!mem_read_enable && !mem_write_enable && mem_address == 64'd0 &&
            mem_xfer_size == 4'd8 && mem_write_data == 64'd0,
            "idle_mem_outputs", mem_address, 64'd0);
      if (mem_read_enable || mem_write_enable) begin
        if (acc_q.size() == 0) begin
          chk(1'b0, "unexpected_access", mem_address, 64'd0);
        end else begin
          a = acc_q.pop_front();
          chk(mem_write_enable == a.we, "access_dir", 64'(mem_write_enable), 64'(a.we));
          chk(mem_address == a.addr, "access_addr", mem_address, a.addr);
          chk(mem_xfer_size == a.size, "access_size", 64'(mem_xfer_size), 64'(a.size));
          if (a.we)
            chk((mem_write_data & a.wmask) == a.wdata, "access_wdata",
                mem_write_data & a.wmask, a.wdata);
        end
      end
      if (done) begin
        if (resp_q.size() == 0) begin
          chk(1'b0, "unexpected_done", 64'(done), 64'd0);
        end else begin
          r = resp_q.pop_front();
          chk(err == r.err, "err", 64'(err), 64'(r.err));
          chk(rdata == r.rdata, "rdata", rdata, r.rdata);
          chk(cyc - r.acc + 1 == r.lat, "latency", 64'(cyc - r.acc + 1), 64'(r.lat));
          chk(!busy, "busy_at_done", 64'(busy), 64'd0);
        end
      end
    end
  end

  // Drive one request, wait for acceptance, push expectations, then jam garbage while busy
  task automatic issue(input logic w, input logic [63:0] a, input logic [3:0] s, input logic [63:0] d);
    int      guard;
    int      sz;
    int      busy_cyc;
    bit      legal;
    bit      aligned;
    logic [63:0] rd;
    resp_t   r;
    access_t e;
    req_write = w; req_addr = a; req_size = s; req_wdata = d; req_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (busy && guard < 200);
    if (busy) begin
      $display("FAIL accept_timeout: busy stuck at %0d expected 0", busy);
      $fatal(1);
    end
    @(posedge clk); #1;
    last_acc = cyc;
    sz = int'(s);
    legal = (sz == 1 || sz == 2 || sz == 4 || sz == 8) && (a < 64'(MEM_SIZE)) &&
            (int'(a) + sz <= int'(MEM_SIZE));
    rd = '0;
    busy_cyc = 0;
    r.lat = 1;
    if (legal) begin
      aligned = (int'(a) % sz) == 0;
      for (int b = 0; b < sz; b++) begin
        if (w) ref_mem[int'(a) + b] = d[8*b +: 8];
        else   rd[8*b +: 8] = ref_mem[int'(a) + b];
      end
      if (aligned) begin
        e.we = w; e.addr = a; e.size = s; e.wmask = mask_of(sz); e.wdata = d & e.wmask;
        acc_q.push_back(e);
        busy_cyc = 1;
        r.lat = 2;
      end else begin
        for (int b = 0; b < sz; b++) begin
          e.we = w; e.addr = a + 64'(b); e.size = 4'd1; e.wmask = '1; e.wdata = 64'(d[8*b +: 8]);
          acc_q.push_back(e);
        end
        busy_cyc = sz;
        r.lat = sz + 1;
      end
    end
    r.err = !legal;
    r.rdata = rd;
    r.acc = cyc;
    resp_q.push_back(r);
    for (int i = 0; i < busy_cyc; i++) begin
      req_valid = 1'b1; req_write = 1'($urandom); req_addr = {$urandom, $urandom};
      req_size = 4'($urandom); req_wdata = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a1;
    int a2;
    logic [63:0] d;
    logic [63:0] addr;
    int sel;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
    req_wdata = '0; mem_clear = 1'b1;
    for (int i = 0; i < int'(MEM_SIZE); i++) ref_mem[i] = init_byte(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
    chk(done == 1'b0, "rst_done", 64'(done), 64'd0);
    chk(err == 1'b0, "rst_err", 64'(err), 64'd0);
    chk(rdata == 64'd0, "rst_rdata", rdata, 64'd0);
    chk(mem_address == 64'd0 && mem_write_data == 64'd0, "rst_mem_addr_data", mem_address, 64'd0);
    chk(mem_xfer_size == 4'd8, "rst_xfer_size", 64'(mem_xfer_size), 64'd8);
    @(posedge clk); #1;
    reset = 1'b0; mem_clear = 1'b0; mon_en = 1'b1;
    @(posedge clk); #1;

    issue(1'b1, 64'h10, 4'd8, 64'h0807060504030201);
    issue(1'b0, 64'h10, 4'd8, 64'd0);
    issue(1'b1, 64'h21, 4'd4, 64'hDDCCBBAA);
    issue(1'b0, 64'h22, 4'd2, 64'd0);
    issue(1'b0, 64'h7C, 4'd8, 64'd0);
    issue(1'b0, 64'h08, 4'd3, 64'd0);
    issue(1'b0, 64'h08, 4'd0, 64'd0);
    issue(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 4'd8, 64'd0);
    issue(1'b0, 64'h78, 4'd8, 64'd0);
    issue(1'b0, 64'h7F, 4'd1, 64'd0);

    issue(1'b0, 64'h10, 4'd8, 64'd0);
    a1 = last_acc;
    issue(1'b0, 64'h18, 4'd8, 64'd0);
    a2 = last_acc;
    chk(a2 - a1 == 2, "back_to_back_accept", 64'(a2 - a1), 64'd2);

    // Reset during the second byte of a misaligned 8-byte store
    d = {$urandom, $urandom};
    req_write = 1'b1; req_addr = 64'h03; req_size = 4'd8; req_wdata = d; req_valid = 1'b1;
    @(negedge clk);
    chk(busy == 1'b0, "rst_test_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    ref_mem[3] = d[7:0];
    acc_q.push_back('{we: 1'b1, addr: 64'h03, size: 4'd1, wdata: 64'(d[7:0]), wmask: '1});
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk(mem_write_enable == 1'b0, "rst_abort_we", 64'(mem_write_enable), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk(busy == 1'b0, "rst_abort_busy", 64'(busy), 64'd0);
    chk(done == 1'b0, "rst_abort_done", 64'(done), 64'd0);
    repeat (4) @(posedge clk);
    #1;

    for (int n = 0; n < 250; n++) begin
      sel = int'($urandom_range(0, 19));
      if (sel == 0)      addr = {$urandom, $urandom};
      else if (sel == 1) addr = 64'(MEM_SIZE - $urandom_range(0, 8));
      else               addr = 64'($urandom_range(0, MEM_SIZE - 1));
      sel = int'($urandom_range(0, 3));
      for (int g = 0; g < sel; g++) begin
        @(posedge clk); #1;
      end
      issue(1'($urandom), addr, size_tab[$urandom_range(0, 15)], {$urandom, $urandom});
    end

    for (int i = 0; i < 100 && (resp_q.size() != 0 || acc_q.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    chk(resp_q.size() == 0, "drain_resp", 64'(resp_q.size()), 64'd0);
    chk(acc_q.size() == 0, "drain_access", 64'(acc_q.size()), 64'd0);
    for (int i = 0; i < int'(MEM_SIZE); i++)
      chk(mem[i] == ref_mem[i], "mem_contents", 64'(mem[i]), 64'(ref_mem[i]));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_splitter.md
MEM_ACCESS_SPLITTER -- requirements
Module: mem_access_splitter

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 128, meaning data memory size in bytes (power of two, >8).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock, all state updates on posedge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 req_valid  input  1  request present; sampled only while busy=0.
REQ-006 req_write  input  1  1=store, 0=load.
REQ-007 req_addr  input  64  byte address, any alignment.
REQ-008 req_size  input  4  transfer size in bytes: 1, 2, 4 or 8.
REQ-009 req_wdata  input  64  store data, little-endian, low req_size bytes valid.
REQ-010 busy  output  1  request in flight; requester SHALL hold request and stall.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  valid with done; request illegal, no memory access made.
REQ-013 rdata  output  64  load result, zero-extended, valid with done.
REQ-014 mem_address  output  64  to data memory.
REQ-015 mem_write_enable  output  1  to data memory.
REQ-016 mem_read_enable  output  1  to data memory.
REQ-017 mem_write_data  output  64  to data memory.
REQ-018 mem_xfer_size  output  4  to data memory.
REQ-019 mem_read_data  input  64  from data memory, combinational read of current mem_* outputs.

Function
REQ-020 SHALL implement states IDLE, ALIGNED, BYTE, DONE; busy=1 in ALIGNED and BYTE only.
REQ-021 SHALL accept a request on a posedge where busy=0 and req_valid=1, latching addr, size, write, wdata.
REQ-022 Illegal request: size not in {1,2,4,8}, or addr+size > MEM_SIZE (computed without 64-bit overflow) -> next state DONE with err=1, no mem enable asserted.
REQ-023 Aligned request (addr & (size-1) == 0) -> ALIGNED for exactly one cycle: mem_address=addr, mem_xfer_size=size, one enable per req_write, mem_write_data=wdata; then DONE.
REQ-024 Misaligned request -> BYTE for exactly size cycles; cycle k (k=0..size-1): mem_address=addr+k, mem_xfer_size=1, mem_write_data[7:0]=wdata[8k+7:8k], upper bits 0; then DONE.
REQ-025 Load in ALIGNED: capture mem_read_data low size bytes into rdata at end of cycle, upper bytes 0.
REQ-026 Load in BYTE cycle k: capture mem_read_data[7:0] into rdata[8k+7:8k]; rdata bytes >= size SHALL be 0.
REQ-027 DONE lasts one cycle: done=1, rdata/err held; store completion has rdata=0.
REQ-028 Latency accept->done: legal aligned 2 cycles, misaligned size+1 cycles, illegal 1 cycle.
REQ-029 A new request MAY be accepted in the DONE cycle (back-to-back); otherwise DONE -> IDLE.
REQ-030 req_valid while busy=1 SHALL be ignored; latched request SHALL not change mid-operation.
REQ-031 Outside ALIGNED/BYTE: mem_read_enable=0, mem_write_enable=0, mem_address=0, mem_xfer_size=8, mem_write_data=0.
REQ-032 Only one of mem_read_enable/mem_write_enable SHALL ever be 1 in a cycle.
REQ-033 rdata and err SHALL be cleared when a new request is accepted.

Reset
REQ-034 On reset: state IDLE, busy=0, done=0, err=0, rdata=0, mem outputs per REQ-031.
REQ-035 Reset during ALIGNED/BYTE SHALL abort: no done pulse, no further mem accesses; bytes already written remain written.
REQ-036 reset has priority over request acceptance in the same cycle.

Verification
REQ-037 Store addr=0x10 size=8 wdata=0x0807060504030201, then load addr=0x10 size=8 -> one ALIGNED cycle each, load done 2 cycles after accept, rdata=0x0807060504030201.
REQ-038 Store addr=0x21 size=4 wdata=0xDDCCBBAA -> four write cycles addresses 0x21..0x24 data AA,BB,CC,DD, done on cycle 5; load addr=0x22 size=2 -> rdata=0xDDCC.
REQ-039 Load addr=0x7C size=8 (MEM_SIZE=128) -> done+err=1 one cycle after accept, no mem enable ever asserted, rdata=0.
REQ-040 Load req_size=3 -> err=1, no access; req_size=0 -> err=1.
REQ-041 Reset asserted in BYTE cycle k=1 of misaligned store size=8 at addr=0x03 -> only byte 0x03 written, IDLE next cycle, no done.
REQ-042 Back-to-back: second request held valid during DONE of first -> accepted that cycle, second done 2 cycles later, busy never asserted for a gap cycle.
